// File: rtl/fifo_word_serializer.sv
// fifo_word_serializer: splits IN_W-bit fifo words into OUT_W-bit beats, framed into PKT_WORDS-word packets
//   clock, reset                              : single clock, synchronous active-high reset
//   io_in_valid/io_in_ready/io_in_bits        : word input, wired to the fifo read port
//   io_out_valid/io_out_ready/io_out_bits     : beat output to the narrow sink
//   io_out_last                               : final beat of a packet, qualified by io_out_valid
//   io_beat_count                             : beats transferred since reset, wrapping
module fifo_word_serializer #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int PKT_WORDS = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [IN_W-1:0]  io_in_bits,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [OUT_W-1:0] io_out_bits,
  output logic             io_out_last,
  output logic [CNT_W-1:0] io_beat_count
);
  localparam int RATIO  = IN_W / OUT_W;
  localparam int IDX_W  = $clog2(RATIO);
  localparam int WORD_W = PKT_WORDS > 1 ? $clog2(PKT_WORDS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(RATIO - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(PKT_WORDS - 1);
  logic [IN_W-1:0]   data_q, data_d;
  logic              full_q, full_d;
  logic [IDX_W-1:0]  idx_q, idx_d, lane;
  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_fire, in_fire, end_word;
  always_comb begin
    out_fire      = full_q & io_out_ready;
    end_word      = out_fire & (idx_q == LAST_IDX);
    // refilling on the final beat keeps back-to-back words bubble-free
    io_in_ready   = !full_q | end_word;
    in_fire       = io_in_valid & io_in_ready;
    lane          = MSB_FIRST ? LAST_IDX - idx_q : idx_q;
    io_out_valid  = full_q;
    io_out_bits   = data_q[lane*OUT_W +: OUT_W];
    io_out_last   = full_q & (idx_q == LAST_IDX) & (word_q == LAST_WORD);
    io_beat_count = cnt_q;
    data_d        = in_fire ? io_in_bits : data_q;
    full_d        = in_fire | (full_q & !end_word);
    idx_d         = (in_fire | end_word) ? '0 : out_fire ? idx_q + IDX_W'(1) : idx_q;
    word_d        = end_word ? (word_q == LAST_WORD ? '0 : word_q + WORD_W'(1)) : word_q;
    cnt_d         = cnt_q + CNT_W'(out_fire);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
      idx_q  <= '0;
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
      idx_q  <= idx_d;
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_word_serializer.sv
// tb_fifo_word_serializer: directed checks of an MSB-first/16-bit-count instance and an LSB-first/4-bit-count instance
module tb_fifo_word_serializer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [31:0] a_in_bits = '0;
  logic        a_in_ready, a_out_valid, a_out_last;
  logic [7:0]  a_out_bits;
  logic [15:0] a_count;
  logic        b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [31:0] b_in_bits = '0;
  logic        b_in_ready, b_out_valid, b_out_last;
  logic [7:0]  b_out_bits;
  logic [3:0]  b_count;
  int          n_vec = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  fifo_word_serializer #(.MSB_FIRST(1'b1), .CNT_W(16)) dut_a (
    .clock(clk), .reset(reset),
    .io_in_valid(a_in_valid), .io_in_ready(a_in_ready), .io_in_bits(a_in_bits),
    .io_out_valid(a_out_valid), .io_out_ready(a_out_ready), .io_out_bits(a_out_bits),
    .io_out_last(a_out_last), .io_beat_count(a_count)
  );
  fifo_word_serializer #(.MSB_FIRST(1'b0), .CNT_W(4)) dut_b (
    .clock(clk), .reset(reset),
    .io_in_valid(b_in_valid), .io_in_ready(b_in_ready), .io_in_bits(b_in_bits),
    .io_out_valid(b_out_valid), .io_out_ready(b_out_ready), .io_out_bits(b_out_bits),
    .io_out_last(b_out_last), .io_beat_count(b_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask
  function automatic logic [31:0] wd(input int w);
    return {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
  endfunction
  task automatic stream_a(input int n);
    a_in_valid = 1'b1;
    a_in_bits  = wd(0);
    step();
    for (int w = 0; w < n; w++)
      for (int b = 0; b < 4; b++) begin
        if (b == 3) begin
          if (w < n - 1) a_in_bits = wd(w + 1);
          else a_in_valid = 1'b0;
        end
        mid();
        chk("stream_valid", 32'(a_out_valid), 32'd1);
        chk("stream_bits", 32'(a_out_bits), 32'(4*w + b));
        chk("stream_last", 32'(a_out_last), 32'(b == 3 && w % 4 == 3));
        chk("stream_in_ready", 32'(a_in_ready), 32'(b == 3));
        step();
      end
    mid();
    chk("stream_drained", 32'(a_out_valid), 32'd0);
  endtask
  initial begin
    logic [7:0] e1 [4];
    logic [7:0] e2 [4];
    logic [7:0] e4 [6];
    logic       r4 [6];
    e1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    e2 = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    e4 = '{8'hDE, 8'hAD, 8'hAD, 8'hAD, 8'hBE, 8'hEF};
    r4 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    a_out_ready = 1'b1;
    step();
    do_reset();
    mid();
    chk("rst_valid", 32'(a_out_valid), 32'd0);
    chk("rst_bits", 32'(a_out_bits), 32'd0);
    chk("rst_last", 32'(a_out_last), 32'd0);
    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    step();
    a_in_valid = 1'b1;
    a_in_bits  = 32'h11223344;
    step();
    a_in_valid = 1'b0;
    a_in_bits  = 'x;
    for (int b = 0; b < 4; b++) begin
      mid();
      chk("t1_valid", 32'(a_out_valid), 32'd1);
      chk("t1_bits", 32'(a_out_bits), 32'(e1[b]));
      chk("t1_in_ready", 32'(a_in_ready), 32'(b == 3));
      chk("t1_last", 32'(a_out_last), 32'd0);
      step();
    end
    mid();
    chk("t1_drained", 32'(a_out_valid), 32'd0);
    chk("t1_count", 32'(a_count), 32'd4);
    do_reset();
    stream_a(8);
    chk("t3_count", 32'(a_count), 32'd32);
    step();
    a_in_valid = 1'b1;
    a_in_bits  = 32'hDEADBEEF;
    step();
    a_in_bits = 32'h01020304;
    for (int k = 0; k < 6; k++) begin
      a_out_ready = r4[k];
      mid();
      chk("t4_valid", 32'(a_out_valid), 32'd1);
      chk("t4_bits", 32'(a_out_bits), 32'(e4[k]));
      chk("t4_last", 32'(a_out_last), 32'd0);
      chk("t4_in_ready", 32'(a_in_ready), 32'(k == 5));
      step();
    end
    a_in_valid = 1'b0;
    mid();
    chk("t4_next_word", 32'(a_out_bits), 32'h01);
    chk("t4_count", 32'(a_count), 32'd36);
    do_reset();
    a_in_valid = 1'b1;
    a_in_bits  = wd(0);
    step();
    for (int k = 0; k < 10; k++) begin
      if (k % 4 == 3) a_in_bits = wd(k / 4 + 1);
      if (k == 9) begin
        reset      = 1'b1;
        a_in_valid = 1'b0;
      end
      mid();
      chk("t5_pre_bits", 32'(a_out_bits), 32'(k));
      step();
    end
    reset = 1'b0;
    mid();
    chk("t5_rst_valid", 32'(a_out_valid), 32'd0);
    chk("t5_rst_count", 32'(a_count), 32'd0);
    chk("t5_rst_last", 32'(a_out_last), 32'd0);
    stream_a(4);
    chk("t5_count", 32'(a_count), 32'd16);
    a_out_ready = 1'b0;
    do_reset();
    b_in_valid  = 1'b1;
    b_in_bits   = 32'hA1B2C3D4;
    b_out_ready = 1'b1;
    step();
    b_in_valid = 1'b0;
    b_in_bits  = 'x;
    for (int b = 0; b < 4; b++) begin
      mid();
      chk("t2_valid", 32'(b_out_valid), 32'd1);
      chk("t2_bits", 32'(b_out_bits), 32'(e2[b]));
      step();
    end
    mid();
    chk("t2_drained", 32'(b_out_valid), 32'd0);
    chk("t2_count", 32'(b_count), 32'd4);
    do_reset();
    b_in_valid = 1'b1;
    b_in_bits  = wd(0);
    step();
    for (int w = 0; w < 5; w++)
      for (int b = 0; b < 4; b++) begin
        if (b == 3) begin
          if (w < 4) b_in_bits = wd(w + 1);
          else b_in_valid = 1'b0;
        end
        mid();
        chk("t6_bits", 32'(b_out_bits), 32'(4*w + 3 - b));
        chk("t6_last", 32'(b_out_last), 32'(b == 3 && w == 3));
        if (4*w + b == 15) chk("t6_count15", 32'(b_count), 32'd15);
        if (4*w + b == 16) chk("t6_count_wrap", 32'(b_count), 32'd0);
        step();
      end
    mid();
    chk("t6_drained", 32'(b_out_valid), 32'd0);
    chk("t6_count_end", 32'(b_count), 32'd4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_word_serializer.md
Name: fifo_word_serializer

Overview:
- Downstream consumer of the 32-bit fifo read port; splits each word into OUT_W-bit beats for a narrow byte-stream sink.
- Connects directly to fifo io_read_valid/io_read_ready/io_read_bits, one clock domain.
- Sustains one output beat per cycle with no bubble between words.
- Frames the stream into packets of PKT_WORDS words, marking the final beat with last; keeps a running beat count.

Parameters:
IN_W, 32, input word width; must equal fifo data width.
OUT_W, 8, output beat width; IN_W must be an integer multiple of OUT_W; RATIO = IN_W/OUT_W >= 2.
MSB_FIRST, 1, 1: beat 0 = bits [IN_W-1 -: OUT_W]; 0: beat 0 = bits [OUT_W-1:0].
PKT_WORDS, 4, words per packet (>= 1); io_out_last marks the final beat of each packet.
CNT_W, 16, width of the running beat counter.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  synchronous, active-high.
io_in_valid  in  1  word available (from fifo io_read_valid).
io_in_ready  out  1  word accepted this cycle when high with io_in_valid (to fifo io_read_ready).
io_in_bits  in  IN_W  word data.
io_out_valid  out  1  beat available.
io_out_ready  in  1  sink accepts beat.
io_out_bits  out  OUT_W  current beat.
io_out_last  out  1  final beat of packet; qualified by io_out_valid.
io_beat_count  out  CNT_W  total beats transferred since reset, wraps modulo 2^CNT_W.

Behaviour:
- Regs: data_q[IN_W], full_q, idx_q (0..RATIO-1), word_q (0..PKT_WORDS-1), cnt_q[CNT_W].
- Reset (sync, dominates all other activity): all regs 0. Outputs next cycle: io_out_valid=0, io_out_bits=0, io_out_last=0, io_beat_count=0, io_in_ready=1.
- Reset mid-word or mid-packet discards the remaining beats; the next word starts a new packet at beat 0.
- io_out_valid = full_q.
- io_out_bits = lane idx_q of data_q, ordered per MSB_FIRST.
- out_fire = io_out_valid & io_out_ready.
- in_fire = io_in_valid & io_in_ready.
- end_word = out_fire & (idx_q == RATIO-1).
- io_in_ready = !full_q | end_word. This is combinational from io_out_ready; a registered fifo read port tolerates the path.
- io_out_last = full_q & (idx_q == RATIO-1) & (word_q == PKT_WORDS-1).
- On in_fire: data_q <= io_in_bits; full_q <= 1; idx_q <= 0.
- Latency: word accepted at edge N gives beat 0 valid in cycle N+1.
- On out_fire with idx_q < RATIO-1: idx_q++.
- On end_word:
  - word_q <= (word_q == PKT_WORDS-1) ? 0 : word_q+1.
  - If in_fire in the same cycle: load the new word, idx_q <= 0, full_q stays 1 (zero-bubble back-to-back).
  - Otherwise full_q <= 0.
- On out_fire: cnt_q++, wrapping at 2^CNT_W-1 -> 0.
- Hold rule: while io_out_valid=1 and io_out_ready=0, io_out_bits and io_out_last stay stable, and io_in_ready=0 if full_q.
- Empty input (io_in_valid=0): io_out_valid drops after the last beat; no spurious beats.
- io_in_bits is sampled only on in_fire; X on io_in_bits while io_in_ready=0 or io_in_valid=0 must not propagate.
- Throughput: RATIO beats per word, 1 beat/cycle when both sides are ready.

Test Plan:
1. Reset, then one word 0x11223344, io_out_ready=1, MSB_FIRST=1 -> beats 0x11,0x22,0x33,0x44 in cycles N+1..N+4; io_in_ready=0 during N+1..N+3; io_beat_count=4.
2. MSB_FIRST=0, word 0xA1B2C3D4 -> beats 0xD4,0xC3,0xB2,0xA1.
3. Fifo holding 8 words, sink always ready -> 32 consecutive valid beats with no gap; io_out_last high only on beats 15 and 31; io_beat_count=32.
4. io_out_ready toggling 1,0,0,1 during word 0xDEADBEEF -> each beat held stable while stalled; io_in_ready stays 0; beat order unchanged.
5. Reset asserted after beat 1 of word 2 in a packet -> next cycle io_out_valid=0 and io_beat_count=0; the following 4 words produce last only on beat 15.
6. CNT_W=4 with 5 words streamed -> io_beat_count goes 15 then 0 then 4 at end (20 mod 16).
